// File: rtl/regfile_sb.sv
// Register file with NUM_RD async read ports, per-register busy scoreboard, flush and busy counter.
// Optional same-cycle writeback-to-read bypass when REGFILE_BYPASS_EN is defined; issue stalls via iss_ready on WAW.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int DBG_REG = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic              wb_fire;
  logic              iss_fire;
  logic              cnt_dec;

  assign wb_fire   = wb_valid && (wb_addr != '0);
  assign iss_ready = !busy[iss_addr] || (iss_addr == '0) || (wb_valid && (wb_addr == iss_addr));
  assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0) && !flush;
  assign cnt_dec   = wb_fire && busy[wb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_fire) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Issue is applied after writeback so a same-cycle reissue leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else if (flush) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wb_fire) begin
        busy[wb_addr] <= 1'b0;
      end
      if (iss_fire) begin
        busy[iss_addr] <= 1'b1;
      end
      cnt <= cnt + {{ADDR_W{1'b0}}, iss_fire} - {{ADDR_W{1'b0}}, cnt_dec};
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
    assign ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ra[i] != '0) begin
        rd_data[i*DATA_W +: DATA_W] = regs[ra[i]];
        rd_busy[i]                  = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && !rst && (wb_addr == ra[i])) begin
          rd_data[i*DATA_W +: DATA_W] = wb_data;
          rd_busy[i]                  = 1'b0;
        end
`endif
      end
    end
  end

  assign busy_cnt = cnt;
  assign dbg_data = regs[DBG_REG];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters), covering both REGFILE_BYPASS_EN builds.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [5:0]  busy_cnt;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .busy_cnt(busy_cnt), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  task automatic iss(input logic v, input logic [4:0] a);
    iss_valid = v;
    iss_addr  = a;
  endtask

  initial begin
    rst = 1'b1;
    rd(5'd0, 5'd0);
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    flush = 1'b0;
    repeat (2) tick();
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_busy_cnt", busy_cnt, 6'd0);
    chk("reset_iss_ready", iss_ready, 1'b1);
    chk("reset_dbg", dbg_data, 32'h0);
    #2 rst = 1'b0;

    // write x5, read back on port0 with port1 at x0
    tick();
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("wr_x5_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("wr_x5_p1_x0", rd_data[63:32], 32'h0);

    // writes to x0 are ignored
    wb(1'b1, 5'd0, 32'h1234);
    rd(5'd5, 5'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_reads_zero", rd_data[63:32], 32'h0);
    chk("x0_busy_zero", rd_busy[1], 1'b0);

    // debug tap on x10
    wb(1'b1, 5'd10, 32'h0000CAFE);
    #1;
    chk("dbg_before_edge", dbg_data, 32'h0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("dbg_after_edge", dbg_data, 32'h0000CAFE);

    // scoreboard: issue x7, WAW stall, writeback release
    iss(1'b1, 5'd7);
    rd(5'd7, 5'd5);
    #1;
    chk("iss_x7_ready", iss_ready, 1'b1);
    tick();
    #1;
    chk("iss_x7_again_stall", iss_ready, 1'b0);
    chk("x7_rd_busy", rd_busy, 2'b01);
    chk("cnt_after_x7", busy_cnt, 6'd1);
    tick();
    iss(1'b0, 5'd0);
    #1;
    chk("cnt_stall_no_effect", busy_cnt, 6'd1);
    wb(1'b1, 5'd7, 32'h55);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wb_x7_busy_same_cycle", rd_busy[0], 1'b0);
`else
    chk("wb_x7_busy_same_cycle", rd_busy[0], 1'b1);
`endif
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("cnt_after_wb_x7", busy_cnt, 6'd0);
    chk("x7_data", rd_data[31:0], 32'h55);
    chk("x7_not_busy", rd_busy[0], 1'b0);

    // same-cycle issue and writeback on busy x3
    iss(1'b1, 5'd3);
    rd(5'd3, 5'd0);
    tick();
    #1;
    chk("cnt_x3", busy_cnt, 6'd1);
    wb(1'b1, 5'd3, 32'h33);
    #1;
    chk("iss_wb_x3_ready", iss_ready, 1'b1);
    tick();
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("iss_wb_x3_cnt", busy_cnt, 6'd1);
    chk("iss_wb_x3_data", rd_data[31:0], 32'h33);
    chk("iss_wb_x3_busy", rd_busy[0], 1'b1);
    wb(1'b1, 5'd3, 32'h34);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("x3_released_cnt", busy_cnt, 6'd0);

    // flush beats a same-cycle issue
    iss(1'b1, 5'd1);
    tick();
    iss(1'b1, 5'd2);
    tick();
    iss(1'b1, 5'd4);
    tick();
    iss(1'b0, 5'd0);
    #1;
    chk("cnt_three", busy_cnt, 6'd3);
    flush = 1'b1;
    iss(1'b1, 5'd6);
    tick();
    flush = 1'b0;
    iss(1'b0, 5'd0);
    rd(5'd6, 5'd1);
    #1;
    chk("flush_cnt", busy_cnt, 6'd0);
    chk("flush_busy_x6_x1", rd_busy, 2'b00);
    rd(5'd5, 5'd7);
    #1;
    chk("flush_data_kept", rd_data, {32'h55, 32'hDEADBEEF});

    // bypass vs plain write-to-read latency on x9
    iss(1'b1, 5'd9);
    tick();
    iss(1'b0, 5'd0);
    rd(5'd9, 5'd0);
    wb(1'b1, 5'd9, 32'hA5A5A5A5);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x9_same_cycle_data", rd_data[31:0], 32'hA5A5A5A5);
    chk("x9_same_cycle_busy", rd_busy[0], 1'b0);
`else
    chk("x9_same_cycle_data", rd_data[31:0], 32'h0);
    chk("x9_same_cycle_busy", rd_busy[0], 1'b1);
`endif
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("x9_next_cycle_data", rd_data[31:0], 32'hA5A5A5A5);
    chk("x9_next_cycle_busy", rd_busy[0], 1'b0);

    // issue one register while writing back another: count is net zero
    iss(1'b1, 5'd12);
    tick();
    iss(1'b1, 5'd13);
    wb(1'b1, 5'd12, 32'h12);
    tick();
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    rd(5'd12, 5'd13);
    #1;
    chk("cnt_swap", busy_cnt, 6'd1);
    chk("busy_swap", rd_busy, 2'b10);

    // asynchronous reset mid-operation
    iss(1'b1, 5'd20);
    tick();
    iss(1'b0, 5'd13);
    rd(5'd5, 5'd7);
    #1;
    chk("cnt_before_rst", busy_cnt, 6'd2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cnt", busy_cnt, 6'd0);
    chk("midrst_iss_ready", iss_ready, 1'b1);
    chk("midrst_rd_data", rd_data, 64'h0);
    chk("midrst_dbg", dbg_data, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
